// File: rtl/gon_pkg.sv
// Shared constants and types for the global output network.
`ifndef NUMS_PE_ROW
`define NUMS_PE_ROW 6
`endif
`ifndef NUMS_PE_COL
`define NUMS_PE_COL 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 32
`endif
`ifndef XID_BITS
`define XID_BITS 4
`endif
`ifndef YID_BITS
`define YID_BITS 3
`endif

package gon_pkg;
  localparam int unsigned GON_ROWS      = `NUMS_PE_ROW;
  localparam int unsigned GON_COLS      = `NUMS_PE_COL;
  localparam int unsigned GON_DATA_BITS = `DATA_BITS;
  localparam int unsigned GON_XID_BITS  = `XID_BITS;
  localparam int unsigned GON_YID_BITS  = `YID_BITS;

  // All-ones IDs mark a PE/row as disabled; they never match any tag.
  localparam logic [GON_XID_BITS-1:0] XID_NONE = '1;
  localparam logic [GON_YID_BITS-1:0] YID_NONE = '1;

  typedef struct packed {
    logic                     valid;
    logic [GON_DATA_BITS-1:0] data;
  } slot_t;
endpackage

// File: rtl/gon_bus.sv
// One PE row: X-ID scan segment, lowest-column select and the row slot register.
module gon_bus
  import gon_pkg::*;
#(
  parameter int unsigned NUMS_PE_COL = GON_COLS,
  parameter int unsigned DATA_BITS   = GON_DATA_BITS,
  parameter int unsigned XID_BITS    = GON_XID_BITS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            set_xid_i,
  input  logic [XID_BITS-1:0]             xid_scan_i,
  output logic [XID_BITS-1:0]             xid_scan_o,
  input  logic                            row_en_i,
  input  logic [XID_BITS-1:0]             tag_x_i,
  input  logic                            cfg_busy_i,
  input  logic [NUMS_PE_COL-1:0]          pe_valid_i,
  input  logic [NUMS_PE_COL*DATA_BITS-1:0] pe_data_i,
  output logic [NUMS_PE_COL-1:0]          pe_ready_c_o,
  output logic                            slot_valid_o,
  output logic [DATA_BITS-1:0]            slot_data_o,
  input  logic                            slot_ready_i
);
  logic [XID_BITS-1:0]    xid_q [NUMS_PE_COL];
  logic [XID_BITS-1:0]    xid_d [NUMS_PE_COL];
  logic                   sel_hit;
  logic [NUMS_PE_COL-1:0] sel_oh;
  logic [DATA_BITS-1:0]   sel_data;
  logic                   accept;
  slot_t                  slot_q, slot_d;

  always_comb begin
    xid_d = xid_q;
    if (set_xid_i) begin
      xid_d[0] = xid_scan_i;
      for (int unsigned c = 1; c < NUMS_PE_COL; c++) xid_d[c] = xid_q[c-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUMS_PE_COL; c++) xid_q[c] <= '1;
    end else begin
      xid_q <= xid_d;
    end
  end

  assign xid_scan_o = xid_q[NUMS_PE_COL-1];

  // Lowest valid column whose enabled X-ID equals the tag.
  always_comb begin
    sel_hit  = 1'b0;
    sel_oh   = '0;
    sel_data = '0;
    for (int unsigned c = 0; c < NUMS_PE_COL; c++) begin
      if (!sel_hit && row_en_i && pe_valid_i[c] &&
          (xid_q[c] == tag_x_i) && !(&xid_q[c])) begin
        sel_hit   = 1'b1;
        sel_oh[c] = 1'b1;
        sel_data  = pe_data_i[c*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign accept       = sel_hit && (!slot_q.valid || slot_ready_i) && !cfg_busy_i;
  assign pe_ready_c_o = accept ? sel_oh : '0;

  always_comb begin
    slot_d = slot_q;
    if (slot_ready_i) slot_d.valid = 1'b0;
    if (accept) begin
      slot_d.valid = 1'b1;
      slot_d.data  = GON_DATA_BITS'(sel_data);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  assign slot_valid_o = slot_q.valid;
  assign slot_data_o  = DATA_BITS'(slot_q.data);
endmodule

// File: rtl/gon.sv
// Global output network top: Y-ID chain, lowest-row arbitration, 2-entry output FIFO.
module gon
  import gon_pkg::*;
#(
  parameter int unsigned NUMS_PE_ROW = `NUMS_PE_ROW,
  parameter int unsigned NUMS_PE_COL = `NUMS_PE_COL,
  parameter int unsigned DATA_BITS   = `DATA_BITS,
  parameter int unsigned XID_BITS    = `XID_BITS,
  parameter int unsigned YID_BITS    = `YID_BITS
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]          PE_valid,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL*DATA_BITS-1:0] PE_data,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]          PE_ready,
  input  logic [XID_BITS-1:0]                         tag_X,
  input  logic [YID_BITS-1:0]                         tag_Y,
  input  logic                                        set_XID,
  input  logic [XID_BITS-1:0]                         XID_scan_in,
  input  logic                                        set_YID,
  input  logic [YID_BITS-1:0]                         YID_scan_in,
  output logic                                        GON_valid,
  input  logic                                        GON_ready,
  output logic [DATA_BITS-1:0]                        GON_data
);
  localparam int unsigned ROW_PE = NUMS_PE_COL;

  logic [YID_BITS-1:0]    yid_q [NUMS_PE_ROW];
  logic [YID_BITS-1:0]    yid_d [NUMS_PE_ROW];
  logic [XID_BITS-1:0]    xid_chain [NUMS_PE_ROW+1];
  logic                   xid_chain_unused;
  logic [NUMS_PE_ROW-1:0] row_en;
  logic [NUMS_PE_ROW-1:0] slot_valid;
  logic [NUMS_PE_ROW-1:0] slot_ready;
  logic [DATA_BITS-1:0]   slot_data [NUMS_PE_ROW];
  logic                   cfg_busy;

  logic                   grant_hit;
  logic [NUMS_PE_ROW-1:0] grant_oh;
  logic [DATA_BITS-1:0]   grant_data;
  logic                   push, pop, wr_idx;
  logic [1:0]             cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   mem_q [2];
  logic [DATA_BITS-1:0]   mem_d [2];
  logic                   valid_q;

  assign cfg_busy = set_XID | set_YID;

  always_comb begin
    yid_d = yid_q;
    if (set_YID) begin
      yid_d[0] = YID_scan_in;
      for (int unsigned r = 1; r < NUMS_PE_ROW; r++) yid_d[r] = yid_q[r-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUMS_PE_ROW; r++) yid_q[r] <= '1;
    end else begin
      yid_q <= yid_d;
    end
  end

  assign xid_chain[0]     = XID_scan_in;
  assign xid_chain_unused = ^xid_chain[NUMS_PE_ROW];

  for (genvar r = 0; r < NUMS_PE_ROW; r++) begin : g_row
    assign row_en[r] = (yid_q[r] == tag_Y) && !(&yid_q[r]);

    gon_bus #(
      .NUMS_PE_COL (NUMS_PE_COL),
      .DATA_BITS   (DATA_BITS),
      .XID_BITS    (XID_BITS)
    ) u_bus (
      .clk          (clk),
      .rst          (rst),
      .set_xid_i    (set_XID),
      .xid_scan_i   (xid_chain[r]),
      .xid_scan_o   (xid_chain[r+1]),
      .row_en_i     (row_en[r]),
      .tag_x_i      (tag_X),
      .cfg_busy_i   (cfg_busy),
      .pe_valid_i   (PE_valid[r*ROW_PE +: ROW_PE]),
      .pe_data_i    (PE_data[r*ROW_PE*DATA_BITS +: ROW_PE*DATA_BITS]),
      .pe_ready_c_o (PE_ready[r*ROW_PE +: ROW_PE]),
      .slot_valid_o (slot_valid[r]),
      .slot_data_o  (slot_data[r]),
      .slot_ready_i (slot_ready[r])
    );
  end

  // Lowest full row slot wins the FIFO write port.
  always_comb begin
    grant_hit  = 1'b0;
    grant_oh   = '0;
    grant_data = '0;
    for (int unsigned r = 0; r < NUMS_PE_ROW; r++) begin
      if (!grant_hit && slot_valid[r]) begin
        grant_hit   = 1'b1;
        grant_oh[r] = 1'b1;
        grant_data  = slot_data[r];
      end
    end
  end

  assign pop        = valid_q && GON_ready;
  assign push       = grant_hit && ((cnt_q != 2'd2) || pop);
  assign slot_ready = push ? grant_oh : '0;
  assign wr_idx     = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !pop);

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    if (pop) mem_d[0] = mem_q[1];
    if (push) mem_d[wr_idx] = grant_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != 2'd0);
      mem_q   <= mem_d;
    end
  end

  assign GON_valid = valid_q;
  assign GON_data  = mem_q[0];
endmodule

// File: tb/tb_gon.sv
// Directed and scoreboarded bench for the global output network.
module tb_gon;
  import gon_pkg::*;

  localparam int unsigned ROWS = 6;
  localparam int unsigned COLS = 8;
  localparam int unsigned NPE  = ROWS * COLS;
  localparam int unsigned DW   = 32;

  logic              clk, rst;
  logic [NPE-1:0]    PE_valid;
  logic [NPE*DW-1:0] PE_data;
  logic [NPE-1:0]    PE_ready;
  logic [3:0]        tag_X, XID_scan_in;
  logic [2:0]        tag_Y, YID_scan_in;
  logic              set_XID, set_YID;
  logic              GON_valid, GON_ready;
  logic [DW-1:0]     GON_data;

  int tests_run, tests_failed;
  int unsigned seq_in [NPE];
  int unsigned seq_out [NPE];

  gon dut (
    .clk(clk), .rst(rst),
    .PE_valid(PE_valid), .PE_data(PE_data), .PE_ready(PE_ready),
    .tag_X(tag_X), .tag_Y(tag_Y),
    .set_XID(set_XID), .XID_scan_in(XID_scan_in),
    .set_YID(set_YID), .YID_scan_in(YID_scan_in),
    .GON_valid(GON_valid), .GON_ready(GON_ready), .GON_data(GON_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int idx, input logic [DW-1:0] v);
    PE_data[idx*DW +: DW] = v;
  endtask

  function automatic logic [NPE-1:0] onehot(input int idx);
    logic [NPE-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  initial begin
    logic [63:0]    r64;
    logic [NPE-1:0] exp_mask;
    int             pe, sum_in, sum_out, mism;

    tests_run = 0; tests_failed = 0;
    rst = 1'b1; PE_valid = '0; PE_data = '0; tag_X = '0; tag_Y = '0;
    set_XID = 1'b0; set_YID = 1'b0; XID_scan_in = '0; YID_scan_in = '0;
    GON_ready = 1'b0;
    for (int i = 0; i < NPE; i++) begin seq_in[i] = 0; seq_out[i] = 0; end

    // Reset state
    #3;
    check("rst_pe_ready", 64'(PE_ready), 64'd0);
    check("rst_gon_valid", 64'(GON_valid), 64'd0);
    check("rst_gon_data", 64'(GON_data), 64'd0);
    tick();
    rst = 1'b0;

    // Unprogrammed IDs never match, even with all-ones tags
    tag_X = XID_NONE; tag_Y = YID_NONE; PE_valid = '1; GON_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("reserved_pe_ready", 64'(PE_ready), 64'd0);
      check("reserved_gon_valid", 64'(GON_valid), 64'd0);
    end

    // Program Y-IDs: row r gets r (last value shifted lands in row 0)
    tag_X = 4'd5; tag_Y = 3'd2;
    set_YID = 1'b1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      YID_scan_in = 3'(r);
      tick();
    end
    set_YID = 1'b0;

    // Program X-IDs: flat index i gets i%8, last-in lands at flat 0
    set_XID = 1'b1;
    for (int i = NPE - 1; i >= 0; i--) begin
      XID_scan_in = 4'(i % 8);
      #1;
      if (i == 0) check("scan_blocks_ready", 64'(PE_ready), 64'd0);
      tick();
    end
    set_XID = 1'b0; PE_valid = '0;
    tick();

    // Single select and 2-cycle latency
    for (int i = 0; i < NPE; i++) set_word(i, 32'h1000_0000 + 32'(i));
    set_word(21, 32'hA5A5_0001);
    PE_valid = '1;
    #1;
    check("sel_onehot_21", 64'(PE_ready), 64'(onehot(21)));
    tick();
    PE_valid = '0;
    check("lat_e0_valid", 64'(GON_valid), 64'd0);
    tick();
    check("lat_e1_valid", 64'(GON_valid), 64'd1);
    check("lat_e1_data", 64'(GON_data), 64'hA5A5_0001);
    tick();
    check("lat_e2_valid", 64'(GON_valid), 64'd0);

    // Backpressure: 3 words absorbed, then drained in order
    GON_ready = 1'b0; PE_valid = onehot(21);
    for (int k = 0; k < 3; k++) begin
      set_word(21, 32'hB000_0000 + 32'(k));
      #1;
      check("bp_accept", 64'(PE_ready), 64'(onehot(21)));
      tick();
    end
    set_word(21, 32'hB000_0003);
    #1;
    check("bp_full_ready", 64'(PE_ready), 64'd0);
    check("bp_full_valid", 64'(GON_valid), 64'd1);
    check("bp_head", 64'(GON_data), 64'hB000_0000);
    tick();
    check("bp_hold_ready", 64'(PE_ready), 64'd0);
    PE_valid = '0; GON_ready = 1'b1;
    tick();
    check("bp_drain1", 64'(GON_data), 64'hB000_0001);
    tick();
    check("bp_drain2", 64'(GON_data), 64'hB000_0002);
    check("bp_drain2_valid", 64'(GON_valid), 64'd1);
    tick();
    check("bp_drained", 64'(GON_valid), 64'd0);

    // Random backpressure with rotating tags, per-PE sequence scoreboard
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (cyc % 50 == 0) begin
        tag_Y = 3'($urandom_range(0, ROWS - 1));
        tag_X = 4'($urandom_range(0, COLS - 1));
      end
      r64 = {$urandom, $urandom};
      PE_valid = r64[NPE-1:0];
      for (int i = 0; i < NPE; i++) set_word(i, {8'(i), 24'(seq_in[i])});
      GON_ready = 1'($urandom_range(0, 1));
      #1;
      exp_mask = onehot(int'(tag_Y) * COLS + int'(tag_X)) & PE_valid;
      check("rnd_ready_subset", 64'(PE_ready & ~exp_mask), 64'd0);
      for (int i = 0; i < NPE; i++) if (PE_ready[i] && PE_valid[i]) seq_in[i]++;
      if (GON_valid && GON_ready) begin
        pe = int'(GON_data[31:24]);
        check("rnd_pe_range", 64'(pe < NPE), 64'd1);
        if (pe < NPE) begin
          check("rnd_order", 64'(GON_data[23:0]), 64'(24'(seq_out[pe])));
          seq_out[pe]++;
        end
      end
      tick();
    end
    PE_valid = '0; GON_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (GON_valid) begin
        pe = int'(GON_data[31:24]);
        if (pe < NPE) begin
          check("drain_order", 64'(GON_data[23:0]), 64'(24'(seq_out[pe])));
          seq_out[pe]++;
        end
      end
      tick();
    end
    sum_in = 0; sum_out = 0; mism = 0;
    for (int i = 0; i < NPE; i++) begin
      sum_in += int'(seq_in[i]);
      sum_out += int'(seq_out[i]);
      if (seq_in[i] != seq_out[i]) mism++;
    end
    check("sb_total", 64'(sum_out), 64'(sum_in));
    check("sb_per_pe", 64'(mism), 64'd0);

    // Two matching columns in row 0: lowest wins first
    set_XID = 1'b1;
    for (int i = NPE - 1; i >= 0; i--) begin
      XID_scan_in = (i == 4) ? 4'd9 : ((i == 3 || i == 6) ? 4'd4 : 4'(i % 8));
      tick();
    end
    set_XID = 1'b0; tag_Y = 3'd0; tag_X = 4'd4;
    set_word(3, 32'hD000_0003); set_word(6, 32'hD000_0006);
    PE_valid = '1;
    #1;
    check("prio_col3", 64'(PE_ready), 64'(onehot(3)));
    tick();
    PE_valid[3] = 1'b0;
    #1;
    check("prio_col6", 64'(PE_ready), 64'(onehot(6)));
    tick();
    PE_valid = '0;
    check("prio_out3", 64'(GON_data), 64'hD000_0003);
    tick();
    check("prio_out6", 64'(GON_data), 64'hD000_0006);
    tick();
    check("prio_empty", 64'(GON_valid), 64'd0);

    // Mid-stream set_XID pulse
    PE_valid = onehot(3);
    set_word(3, 32'hC000_0000);
    tick();
    set_word(3, 32'hC000_0001);
    tick();
    check("cfg_head", 64'(GON_data), 64'hC000_0000);
    set_XID = 1'b1; XID_scan_in = 4'd0; set_word(3, 32'hC000_0002);
    #1;
    check("cfg_ready_low", 64'(PE_ready), 64'd0);
    tick();
    set_XID = 1'b0; PE_valid = '0;
    check("cfg_buffered_valid", 64'(GON_valid), 64'd1);
    check("cfg_buffered_data", 64'(GON_data), 64'hC000_0001);
    tick();
    check("cfg_no_capture", 64'(GON_valid), 64'd0);

    // Fill FIFO (IDs shifted by one: row 0 col 4 now holds X-ID 4), then reset
    GON_ready = 1'b0; PE_valid = onehot(4);
    for (int k = 0; k < 3; k++) begin
      set_word(4, 32'hE000_0000 + 32'(k));
      #1;
      check("fill_accept", 64'(PE_ready), 64'(onehot(4)));
      tick();
    end
    check("fill_full", 64'(PE_ready), 64'd0);
    check("fill_valid", 64'(GON_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(GON_valid), 64'd0);
    check("async_rst_data", 64'(GON_data), 64'd0);
    check("async_rst_ready", 64'(PE_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ids", 64'(PE_ready), 64'd0);
    tick();
    check("post_rst_valid", 64'(GON_valid), 64'd0);
    check("post_rst_ready", 64'(PE_ready), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
